// File: rtl/round_banner_fetch.sv
// Sprite-fetch stage for the "Round N" banner: frame-counting show FSM plus a
// three-stage pixel pipeline (address, ROM wait, colour index register).
module round_banner_fetch #(
  parameter int SPRITE_W        = 64,
  parameter int SPRITE_H        = 32,
  parameter int X0              = 288,
  parameter int Y0              = 224,
  parameter int SHOW_FRAMES     = 120,
  parameter int TRANSPARENT_IDX = 0,
  parameter int AW              = $clog2(SPRITE_W*SPRITE_H)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          frame_start,
  input  logic [9:0]    drawX,
  input  logic [9:0]    drawY,
  input  logic          blank,
  output logic [AW-1:0] rom_addr,
  input  logic [3:0]    rom_data,
  output logic [3:0]    index,
  output logic          index_valid,
  output logic          busy
);

  localparam int FW = $clog2(SHOW_FRAMES+1);

  // Box bounds widened to 11 bits so X0+SPRITE_W cannot wrap.
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + SPRITE_W);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + SPRITE_H);

  typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;

  state_t        state_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic          vis_d1_reg;
  logic          vis_d2_reg;

  logic [10:0]   x11;
  logic [10:0]   y11;
  logic [10:0]   dx;
  logic [10:0]   dy;
  logic          in_box;
  logic [AW-1:0] addr_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_reg <= ARMED;
        end
        ARMED: begin
          if (frame_start) begin
            state_reg     <= SHOW;
            frame_cnt_reg <= '0;
          end
        end
        SHOW: begin
          // A restart wins over a simultaneous terminal frame_start.
          if (start) begin
            frame_cnt_reg <= '0;
          end else if (frame_start) begin
            if (frame_cnt_reg == FW'(SHOW_FRAMES - 1)) begin
              state_reg <= IDLE;
            end else begin
              frame_cnt_reg <= frame_cnt_reg + FW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

  always_comb begin
    x11       = {1'b0, drawX};
    y11       = {1'b0, drawY};
    dx        = x11 - X_LO;
    dy        = y11 - Y_LO;
    in_box    = blank && (state_reg == SHOW) &&
                (x11 >= X_LO) && (x11 < X_HI) &&
                (y11 >= Y_LO) && (y11 < Y_HI);
    addr_next = AW'(({21'd0, dy} * 32'(SPRITE_W)) + {21'd0, dx});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rom_addr    <= '0;
      vis_d1_reg  <= 1'b0;
      vis_d2_reg  <= 1'b0;
      index       <= 4'd0;
      index_valid <= 1'b0;
    end else begin
      rom_addr    <= in_box ? addr_next : '0;
      vis_d1_reg  <= in_box;
      vis_d2_reg  <= vis_d1_reg;
      // rom_data corresponds to the pixel now held in vis_d2_reg.
      index       <= vis_d2_reg ? rom_data : 4'd0;
      index_valid <= vis_d2_reg && (rom_data != 4'(TRANSPARENT_IDX));
    end
  end

endmodule

// File: tb/tb_round_banner_fetch.sv
// Directed bench for round_banner_fetch with SHOW_FRAMES=4: reset, box edges,
// transparency, frame expiry, restart and mid-show reset.
module tb_round_banner_fetch;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        frame_start;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic        blank;
  logic [10:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  index;
  logic        index_valid;
  logic        busy;

  int vectors;
  int miscompares;

  round_banner_fetch #(.SHOW_FRAMES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .frame_start (frame_start),
    .drawX       (drawX),
    .drawY       (drawY),
    .blank       (blank),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .index       (index),
    .index_valid (index_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel through the pipeline: address after the sampling edge, index two edges later.
  task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic b, input logic [3:0] romval,
                       input logic [10:0] exp_addr, input logic [3:0] exp_idx,
                       input logic exp_vld);
    @(negedge clk);
    drawX = x; drawY = y; blank = b;
    @(posedge clk); #1;
    chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    drawX = 10'd0; drawY = 10'd0; blank = 1'b0;
    @(posedge clk); #1;
    rom_data = romval;
    @(posedge clk); #1;
    chk({tag, ".index"}, 32'(index), 32'(exp_idx));
    chk({tag, ".valid"}, 32'(index_valid), 32'(exp_vld));
    rom_data = 4'd0;
  endtask

  task automatic pulse(input string tag, input logic s, input logic f, input logic exp_busy);
    @(negedge clk);
    start = s; frame_start = f;
    @(posedge clk); #1;
    start = 1'b0; frame_start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; start = 1'b0; frame_start = 1'b0;
    drawX = 10'd0; drawY = 10'd0; blank = 1'b0; rom_data = 4'd0;

    // Reset held for 3 clocks with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom); frame_start = 1'($urandom);
      drawX = 10'($urandom); drawY = 10'($urandom);
      blank = 1'($urandom); rom_data = 4'($urandom);
      @(posedge clk); #1;
      chk("rst.addr",  32'(rom_addr),    32'd0);
      chk("rst.index", 32'(index),       32'd0);
      chk("rst.valid", 32'(index_valid), 32'd0);
      chk("rst.busy",  32'(busy),        32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1; start = 1'b0; frame_start = 1'b0; blank = 1'b0; rom_data = 4'd0;

    pixel("idle_px", 10'd290, 10'd225, 1'b1, 4'd5, 11'd0, 4'd0, 1'b0);
    pulse("start", 1'b1, 1'b0, 1'b1);
    pixel("armed_px", 10'd290, 10'd225, 1'b1, 4'd5, 11'd0, 4'd0, 1'b0);
    pulse("armed_start", 1'b1, 1'b0, 1'b1);
    pulse("enter_show", 1'b0, 1'b1, 1'b1);

    // Main function and box edges
    pixel("basic",     10'd290, 10'd225, 1'b1, 4'd5,  11'd66,   4'd5,  1'b1);
    pixel("transp",    10'd300, 10'd230, 1'b1, 4'd0,  11'd396,  4'd0,  1'b0);
    pixel("x_last",    10'd351, 10'd226, 1'b1, 4'd9,  11'd191,  4'd9,  1'b1);
    pixel("x_out",     10'd352, 10'd226, 1'b1, 4'd9,  11'd0,    4'd0,  1'b0);
    pixel("blanked",   10'd290, 10'd225, 1'b0, 4'd5,  11'd0,    4'd0,  1'b0);
    pixel("y_last",    10'd288, 10'd255, 1'b1, 4'd3,  11'd1984, 4'd3,  1'b1);
    pixel("y_out",     10'd288, 10'd256, 1'b1, 4'd3,  11'd0,    4'd0,  1'b0);
    pixel("x_left",    10'd287, 10'd224, 1'b1, 4'd6,  11'd0,    4'd0,  1'b0);
    pixel("origin",    10'd288, 10'd224, 1'b1, 4'd7,  11'd0,    4'd7,  1'b1);
    pixel("corner",    10'd351, 10'd255, 1'b1, 4'd15, 11'd2047, 4'd15, 1'b1);

    // Expiry after 4 frames
    pulse("exp_f1", 1'b0, 1'b1, 1'b1);
    pulse("exp_f2", 1'b0, 1'b1, 1'b1);
    pulse("exp_f3", 1'b0, 1'b1, 1'b1);
    pixel("exp_pre", 10'd290, 10'd225, 1'b1, 4'd5, 11'd66, 4'd5, 1'b1);
    pulse("exp_f4", 1'b0, 1'b1, 1'b0);
    pixel("exp_post", 10'd290, 10'd225, 1'b1, 4'd5, 11'd0, 4'd0, 1'b0);

    // Restart coincident with terminal frame_start
    pulse("rs_start", 1'b1, 1'b0, 1'b1);
    pulse("rs_enter", 1'b0, 1'b1, 1'b1);
    pulse("rs_f1", 1'b0, 1'b1, 1'b1);
    pulse("rs_f2", 1'b0, 1'b1, 1'b1);
    pulse("rs_f3", 1'b0, 1'b1, 1'b1);
    pulse("rs_term_start", 1'b1, 1'b1, 1'b1);
    pixel("rs_px0", 10'd291, 10'd225, 1'b1, 4'd4, 11'd67, 4'd4, 1'b1);
    pulse("rs_g1", 1'b0, 1'b1, 1'b1);
    pulse("rs_g2", 1'b0, 1'b1, 1'b1);
    pulse("rs_g3", 1'b0, 1'b1, 1'b1);
    pixel("rs_px3", 10'd291, 10'd225, 1'b1, 4'd4, 11'd67, 4'd4, 1'b1);
    pulse("rs_g4", 1'b0, 1'b1, 1'b0);
    pixel("rs_post", 10'd291, 10'd225, 1'b1, 4'd4, 11'd0, 4'd0, 1'b0);

    // Reset mid-SHOW at frame_cnt=2 with the pipeline full
    pulse("mr_start", 1'b1, 1'b0, 1'b1);
    pulse("mr_enter", 1'b0, 1'b1, 1'b1);
    pulse("mr_f1", 1'b0, 1'b1, 1'b1);
    pulse("mr_f2", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drawX = 10'd290; drawY = 10'd225; blank = 1'b1; rom_data = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_full.addr",  32'(rom_addr),    32'd66);
    chk("mr_full.valid", 32'(index_valid), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mr.busy",  32'(busy),        32'd0);
    chk("mr.addr",  32'(rom_addr),    32'd0);
    chk("mr.index", 32'(index),       32'd0);
    chk("mr.valid", 32'(index_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; blank = 1'b0; rom_data = 4'd0;
    pulse("mr_frame", 1'b0, 1'b1, 1'b0);
    pixel("mr_px", 10'd290, 10'd225, 1'b1, 4'd5, 11'd0, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
